// File: rtl/npu_pkg.sv
// Shared constants, FSM encoding and helpers for the count-to-unary serializer.
package npu_pkg;

  localparam int unsigned N_BITS_DEFAULT = 11;
  localparam int unsigned CW_DEFAULT     = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Saturate a requested count to the frame length.
  function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned limit);
    return (cnt > limit) ? limit : cnt;
  endfunction

endpackage

// File: rtl/unary_mask_gen.sv
// Combinational count-to-thermometer mask; MSB_FIRST moves the ones to the top indices.
module unary_mask_gen
  import npu_pkg::*;
#(
  parameter int unsigned N_BITS    = N_BITS_DEFAULT,
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic [CW-1:0]     i_count,
  output logic [N_BITS-1:0] o_mask
);

  // i + count >= N_BITS is the underflow-free form of i >= N_BITS - count
  always_comb begin
    o_mask = '0;
    for (int unsigned i = 0; i < N_BITS; i++) begin
      if (MSB_FIRST != 0) o_mask[i] = ((i + 32'(i_count)) >= N_BITS);
      else                o_mask[i] = (i < 32'(i_count));
    end
  end

endmodule

// File: rtl/count_to_unary_serializer.sv
// Accepts a count over valid/ready and emits an N_BITS-long unary bit stream with a parallel mask copy.
module count_to_unary_serializer
  import npu_pkg::*;
#(
  parameter int unsigned N_BITS    = N_BITS_DEFAULT,
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_first,
  output logic              out_last,
  output logic [N_BITS-1:0] mask,
  output logic              sat_err,
  output logic              busy
);

  localparam int unsigned   IW       = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BITS - 1);

  logic [0:0]        r_state;
  logic [IW-1:0]     r_idx;
  logic [N_BITS-1:0] r_mask;
  logic              r_rdy;
  logic              r_out_bit;
  logic              r_out_first;
  logic              r_out_last;
  logic              r_sat_err;

  logic [0:0]        w_state_nxt;
  logic [IW-1:0]     w_idx_nxt;
  logic [N_BITS-1:0] w_mask_nxt;
  logic [N_BITS-1:0] w_mask_new;
  logic [CW-1:0]     w_count_clamp;
  logic              w_last;
  logic              w_xfer;
  logic              w_in_ready_c;
  logic              w_accept;

  assign w_count_clamp = CW'(clamp_count(32'(in_count), N_BITS));

  unary_mask_gen #(
    .N_BITS    (N_BITS),
    .CW        (CW),
    .MSB_FIRST (MSB_FIRST)
  ) u_mask_gen (
    .i_count (w_count_clamp),
    .o_mask  (w_mask_new)
  );

  // r_rdy keeps in_ready low during reset and for the first cycle after release
  assign w_last       = (r_idx == LAST_IDX);
  assign w_xfer       = (r_state == ST_SHIFT) && out_ready;
  assign w_in_ready_c = r_rdy || (w_xfer && w_last);
  assign w_accept     = in_valid && w_in_ready_c;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mask_nxt  = r_mask;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_idx_nxt   = '0;
          w_mask_nxt  = w_mask_new;
        end
      end
      ST_SHIFT: begin
        if (w_xfer) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + IW'(1);
          end else if (w_accept) begin
            // last-bit handoff: next frame starts without a bubble
            w_idx_nxt  = '0;
            w_mask_nxt = w_mask_new;
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_mask_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_mask_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_mask      <= '0;
      r_rdy       <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_sat_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_mask      <= w_mask_nxt;
      r_rdy       <= (w_state_nxt == ST_IDLE);
      r_out_bit   <= (w_state_nxt == ST_SHIFT) && w_mask_nxt[w_idx_nxt];
      r_out_first <= (w_state_nxt == ST_SHIFT) && (w_idx_nxt == '0);
      r_out_last  <= (w_state_nxt == ST_SHIFT) && (w_idx_nxt == LAST_IDX);
      r_sat_err   <= w_accept && (32'(in_count) > N_BITS);
    end
  end

  assign in_ready  = w_in_ready_c;
  assign out_valid = (r_state == ST_SHIFT);
  assign busy      = (r_state == ST_SHIFT);
  assign out_bit   = r_out_bit;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign mask      = r_mask;
  assign sat_err   = r_sat_err;

endmodule
